// File: rtl/sram_clr_p.sv
// Parametrised single-port SRAM with read-valid flag and a multi-cycle clear engine.
// Optional even-parity protection is enabled by defining SRAM_CLR_PARITY_EN.
module sram_clr_p #(
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 4,
    parameter int unsigned CLR_ON_RESET = 0
) (
    input  logic          clk,
    input  logic          res,
    input  logic          cs,
    input  logic          wr,
    input  logic          rd,
    input  logic          clr,
    input  logic [AW-1:0] add,
    input  logic [DW-1:0] datain,
`ifdef SRAM_CLR_PARITY_EN
    input  logic          perr_inj,
    output logic          perr,
`endif
    output logic [DW-1:0] datao,
    output logic          dvalid,
    output logic          busy,
    output logic          clr_done
);

    localparam int unsigned DEPTH = 1 << AW;
`ifdef SRAM_CLR_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          pend, pend_nxt;
    logic [DW-1:0] datao_nxt;
    logic          dvalid_nxt;
    logic          busy_nxt;
    logic          clr_done_nxt;
`ifdef SRAM_CLR_PARITY_EN
    logic          perr_nxt;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [MW-1:0] mem_wd;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

`ifdef SRAM_CLR_PARITY_EN
    assign wr_word = {(^datain) ^ perr_inj, datain};
`else
    assign wr_word = datain;
`endif
    assign rd_word = mem[add];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pend_nxt   = pend;
        datao_nxt  = datao;
        dvalid_nxt = 1'b0;
        busy_nxt   = busy;
        mem_we     = 1'b0;
        mem_wa     = add;
        mem_wd     = wr_word;
`ifdef SRAM_CLR_PARITY_EN
        perr_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A pending power-on sweep pre-empts whatever command is present.
                if (pend) begin
                    pend_nxt  = 1'b0;
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end else if (cs) begin
                    if (wr) begin
                        mem_we = 1'b1;
                    end else if (rd) begin
                        datao_nxt  = rd_word[DW-1:0];
                        dvalid_nxt = 1'b1;
`ifdef SRAM_CLR_PARITY_EN
                        perr_nxt   = rd_word[DW] ^ (^rd_word[DW-1:0]);
`endif
                    end else if (clr) begin
                        state_nxt = CLEAR;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                mem_we  = 1'b1;
                mem_wa  = cnt;
                mem_wd  = '0;
                cnt_nxt = cnt + AW'(1);
                if (cnt == '1) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Registered pulse lands in the cycle whose closing edge writes the last word.
        clr_done_nxt = (state_nxt == CLEAR) && (cnt_nxt == '1);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= (CLR_ON_RESET != 0);
            datao    <= '0;
            dvalid   <= 1'b0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
`ifdef SRAM_CLR_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            datao    <= datao_nxt;
            dvalid   <= dvalid_nxt;
            busy     <= busy_nxt;
            clr_done <= clr_done_nxt;
`ifdef SRAM_CLR_PARITY_EN
            perr     <= perr_nxt;
`endif
        end
    end

    // Array is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && res) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_sram_clr_p.sv
// Randomised self-checking bench for sram_clr_p against a cycle-level reference model.
module tb_sram_clr_p;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, cs, wr, rd, clr, perr_inj;
    logic [AW-1:0] add;
    logic [DW-1:0] datain, datao;
    logic          dvalid, busy, clr_done;
`ifdef SRAM_CLR_PARITY_EN
    logic          perr;
`endif

    logic          res2, cs2, wr2, rd2, clr2, perr_inj2;
    logic [2:0]    add2;
    logic [15:0]   din2, datao2;
    logic          dvalid2, busy2, clr_done2;
`ifdef SRAM_CLR_PARITY_EN
    logic          perr2;
`endif

    sram_clr_p #(.DW(DW), .AW(AW), .CLR_ON_RESET(0)) dut (
        .clk(clk), .res(res), .cs(cs), .wr(wr), .rd(rd), .clr(clr),
        .add(add), .datain(datain),
`ifdef SRAM_CLR_PARITY_EN
        .perr_inj(perr_inj), .perr(perr),
`endif
        .datao(datao), .dvalid(dvalid), .busy(busy), .clr_done(clr_done)
    );

    sram_clr_p #(.DW(16), .AW(3), .CLR_ON_RESET(1)) dut2 (
        .clk(clk), .res(res2), .cs(cs2), .wr(wr2), .rd(rd2), .clr(clr2),
        .add(add2), .datain(din2),
`ifdef SRAM_CLR_PARITY_EN
        .perr_inj(perr_inj2), .perr(perr2),
`endif
        .datao(datao2), .dvalid(dvalid2), .busy(busy2), .clr_done(clr_done2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    bit            ref_perr  [DEPTH];
    int            sweep_left;
    logic [DW-1:0] exp_datao;
    bit            exp_datao_known;
    bit            exp_dvalid, exp_busy, exp_done, exp_perr;
    logic [15:0]   d2_val [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        if (exp_datao_known) check({tag, "_datao"}, datao, exp_datao);
        check({tag, "_dvalid"}, dvalid, exp_dvalid);
        check({tag, "_busy"}, busy, exp_busy);
        check({tag, "_clr_done"}, clr_done, exp_done);
`ifdef SRAM_CLR_PARITY_EN
        check({tag, "_perr"}, perr, exp_perr);
`endif
    endtask

    // One clock of stimulus; the model decides what the memory should have done.
    task automatic step(input string tag, input bit c, input bit w, input bit r, input bit k,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input bit inj);
        cs = c; wr = w; rd = r; clr = k; add = a; datain = d; perr_inj = inj;
        exp_dvalid = 1'b0;
        exp_perr   = 1'b0;
        if (sweep_left > 0) begin
            ref_mem[DEPTH - sweep_left]   = '0;
            ref_known[DEPTH - sweep_left] = 1'b1;
            ref_perr[DEPTH - sweep_left]  = 1'b0;
            sweep_left--;
        end else if (c && w) begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
            ref_perr[a]  = inj;
        end else if (c && r) begin
            exp_datao       = ref_mem[a];
            exp_datao_known = ref_known[a];
            exp_dvalid      = 1'b1;
            exp_perr        = ref_perr[a];
        end else if (c && k) begin
            sweep_left = DEPTH;
        end
        exp_busy = (sweep_left > 0);
        exp_done = (sweep_left == 1);
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag, input int cycles);
        res = 1'b0;
        #1;
        sweep_left      = 0;
        exp_datao       = '0;
        exp_datao_known = 1'b1;
        exp_dvalid      = 1'b0;
        exp_busy        = 1'b0;
        exp_done        = 1'b0;
        exp_perr        = 1'b0;
        check_outputs(tag);
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        check_outputs(tag);
        res = 1'b1;
    endtask

    task automatic d2_auto_sweep(input string tag);
        res2 = 1'b1;
        check({tag, "_busy_pre"}, busy2, 0);
        for (int i = 0; i < 9; i++) begin
            cs2 = 1'b1; wr2 = 1'b1; rd2 = 1'($urandom_range(0, 1)); clr2 = 1'b0;
            add2 = 3'(i); din2 = 16'($urandom) | 16'h0001;
            @(posedge clk); #1;
            check({tag, "_busy"}, busy2, (i < 8));
            check({tag, "_done"}, clr_done2, (i == 7));
            check({tag, "_dvalid"}, dvalid2, 0);
        end
        wr2 = 1'b0; rd2 = 1'b0; cs2 = 1'b0;
    endtask

    initial begin
        res = 1'b0; cs = 0; wr = 0; rd = 0; clr = 0; add = '0; datain = '0; perr_inj = 0;
        res2 = 1'b0; cs2 = 0; wr2 = 0; rd2 = 0; clr2 = 0; add2 = '0; din2 = '0; perr_inj2 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_known[i] = 1'b0;
            ref_perr[i]  = 1'b0;
            ref_mem[i]   = '0;
        end
        @(posedge clk); #1;

        // Reset, then write/read with a single-cycle dvalid
        apply_reset("rst", 2);
        step("t1_wr", 1, 1, 0, 0, 4'd1, 8'h02, 0);
        step("t1_rd", 1, 0, 1, 0, 4'd1, 8'h00, 0);
        step("t1_idle", 0, 0, 0, 0, 4'd0, 8'h00, 0);

        // Priority and chip select
        step("t2_wrrd", 1, 1, 1, 0, 4'd5, 8'h22, 0);
        step("t2_rd", 1, 0, 1, 0, 4'd5, 8'h00, 0);
        step("t2_nocs", 0, 1, 0, 0, 4'd5, 8'hFF, 0);
        step("t2_rd2", 1, 0, 1, 0, 4'd5, 8'h00, 0);
        step("t2_wrclr", 1, 1, 0, 1, 4'd6, 8'h33, 0);
        step("t2_rdclr", 1, 0, 1, 1, 4'd6, 8'h00, 0);

        // Full clear sweep with commands hammered during busy
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 1, 1, 0, 0, 4'(i), 8'hA5, 0);
        step("t3_clr", 1, 0, 0, 1, 4'd0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++)
            step("t3_sweep", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom), 8'($urandom), 0);
        for (int i = 0; i < DEPTH; i++) step("t3_rd", 1, 0, 1, 0, 4'(i), 8'h00, 0);

        // Reset six cycles into a sweep
        for (int i = 0; i < DEPTH; i++) step("t4_fill", 1, 1, 0, 0, 4'(i), 8'h5A, 0);
        step("t4_clr", 1, 0, 0, 1, 4'd0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step("t4_sweep", 0, 0, 0, 0, 4'd0, 8'h00, 0);
        apply_reset("t4_rst", 2);
        for (int i = 0; i < DEPTH; i++) step("t4_rd", 1, 0, 1, 0, 4'(i), 8'h00, 0);

        // Parity injection (model tracks it regardless; checked only when present)
        step("t6_wr_inj", 1, 1, 0, 0, 4'd13, 8'hE2, 1);
        step("t6_rd_inj", 1, 0, 1, 0, 4'd13, 8'h00, 0);
        step("t6_wr", 1, 1, 0, 0, 4'd13, 8'hE2, 0);
        step("t6_rd", 1, 0, 1, 0, 4'd13, 8'h00, 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++)
            step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 20) == 0),
                 4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Auto clear on reset release (AW=3, DW=16)
        d2_auto_sweep("t5a");
        for (int i = 0; i < 8; i++) begin
            d2_val[i] = 16'($urandom) | 16'h8000;
            cs2 = 1'b1; wr2 = 1'b1; add2 = 3'(i); din2 = d2_val[i];
            @(posedge clk); #1;
        end
        wr2 = 1'b0; rd2 = 1'b1; add2 = 3'd3;
        @(posedge clk); #1;
        check("t5_prefill", datao2, d2_val[3]);
        check("t5_prefill_dv", dvalid2, 1);
        rd2 = 1'b0; cs2 = 1'b0;
        res2 = 1'b0;
        #1;
        check("t5_rst_datao", datao2, 0);
        check("t5_rst_busy", busy2, 0);
        @(posedge clk); #1;
        d2_auto_sweep("t5b");
        for (int i = 0; i < 8; i++) begin
            cs2 = 1'b1; rd2 = 1'b1; add2 = 3'(i);
            @(posedge clk); #1;
            check("t5_rd", datao2, 16'h0000);
            check("t5_rd_dv", dvalid2, 1);
        end
        cs2 = 1'b0; rd2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
